datapath_seq: RTL and testbench

Parametrised successor to the lab datapath. It combines a register file, an A/B/C pipeline-register datapath (shifter and ALU) and a status register with an internal micro-sequencer. The sequencer executes one complete register-transfer instruction per accepted command, accepted over a valid/ready handshake, so the external controller no longer drives loada/loadb/asel/vsel per cycle. It sits between the instruction decoder and the register/ALU hardware of the CPU.

---
 rtl/datapath_seq_pkg.sv | 41 ++++
 rtl/datapath_seq_if.sv | 37 +++
 rtl/datapath_seq_alu_shift.sv | 55 +++++
 rtl/datapath_seq.sv | 146 ++++++++++++++
 tb/tb_datapath_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_seq_pkg.sv
// Shared types for the sequenced register-file / ALU datapath:
// command opcodes, shifter modes, sequencer states and status flags.
package datapath_seq_pkg;

  typedef enum logic [2:0] {
    OP_MOVI = 3'd0,
    OP_MOV  = 3'd1,
    OP_ADD  = 3'd2,
    OP_CMP  = 3'd3,
    OP_AND  = 3'd4,
    OP_MVN  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_LSL1 = 2'd1,
    SH_LSR1 = 2'd2,
    SH_ASR1 = 2'd3
  } shift_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GETA = 3'd1,
    S_GETB = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_WIMM = 3'd5
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

  // Only arithmetic/logic results update status; moves leave it alone.
  function automatic logic op_sets_flags(op_e op);
    return op inside {OP_ADD, OP_CMP, OP_AND, OP_MVN};
  endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// Command handshake, result/status and debug read port of datapath_seq.
// The master side is the instruction decoder, the slave side the datapath.
interface datapath_seq_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
);
  import datapath_seq_pkg::*;

  localparam int RA_W = $clog2(NREG);

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [RA_W-1:0]   cmd_rd;
  logic [RA_W-1:0]   cmd_rn;
  logic [RA_W-1:0]   cmd_rm;
  shift_e            cmd_shift;
  logic [DATA_W-1:0] cmd_imm;
  logic              done;
  logic [DATA_W-1:0] datapath_out;
  logic              Z_out;
  logic              N_out;
  logic              V_out;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm, dbg_addr,
    input  cmd_ready, done, datapath_out, Z_out, N_out, V_out, dbg_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm, dbg_addr,
    output cmd_ready, done, datapath_out, Z_out, N_out, V_out, dbg_data
  );

endinterface

// File: rtl/datapath_seq_alu_shift.sv
// Combinational one-bit shifter on the B operand followed by the ALU.
// Produces the result and the Z/N/V flags for that result.
module dp_alu_shift
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  op_e               i_op,
  input  shift_e            i_shift,
  output logic [DATA_W-1:0] o_result,
  output flags_t            o_flags
);

  logic [DATA_W-1:0] w_bs;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_v;

  assign w_sum  = i_a + w_bs;
  assign w_diff = i_a - w_bs;

  // Shift B by one place; ASR keeps the sign bit, LSR fills with zero.
  always_comb begin
    w_bs = i_b;
    case (i_shift)
      SH_LSL1: w_bs = {i_b[DATA_W-2:0], 1'b0};
      SH_LSR1: w_bs = {1'b0, i_b[DATA_W-1:1]};
      SH_ASR1: w_bs = {i_b[DATA_W-1], i_b[DATA_W-1:1]};
      default: w_bs = i_b;
    endcase
  end

  // Select the operation result; overflow only exists for add and subtract.
  always_comb begin
    o_result = w_bs;
    w_v      = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum;
        w_v = (i_a[DATA_W-1] == w_bs[DATA_W-1]) && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_CMP: begin
        o_result = w_diff;
        w_v = (i_a[DATA_W-1] != w_bs[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_AND:  o_result = i_a & w_bs;
      OP_MVN:  o_result = ~w_bs;
      default: o_result = w_bs;
    endcase
    o_flags = '{z: (o_result == '0), n: o_result[DATA_W-1], v: w_v};
  end

endmodule

// File: rtl/datapath_seq.sv
// Register file plus A/B/C pipeline registers and status, driven by a
// micro-sequencer that runs one whole register-transfer instruction per
// accepted command.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input logic           clk,
  input logic           reset,
  datapath_seq_if.slave bus
);

  localparam int RA_W = $clog2(NREG);

  state_e            r_state;
  state_e            w_state_next;
  op_e               r_op;
  logic [RA_W-1:0]   r_rd;
  logic [RA_W-1:0]   r_rn;
  logic [RA_W-1:0]   r_rm;
  shift_e            r_shift;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  flags_t            r_flags;
  logic              r_done;
  logic [DATA_W-1:0] w_alu_result;
  flags_t            w_alu_flags;
  logic              w_accept;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_wr_data;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);

  dp_alu_shift #(.DATA_W(DATA_W)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .i_shift  (r_shift),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: the op picks the path out of IDLE; CMP skips write-back.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_MOVI:                 w_state_next = S_WIMM;
            OP_MOV, OP_MVN:          w_state_next = S_GETB;
            OP_ADD, OP_AND, OP_CMP:  w_state_next = S_GETA;
            default:                 w_state_next = S_IDLE;
          endcase
        end
      end
      S_GETA:  w_state_next = S_GETB;
      S_GETB:  w_state_next = S_EXEC;
      S_EXEC:  w_state_next = (r_op == OP_CMP) ? S_IDLE : S_WB;
      S_WB:    w_state_next = S_IDLE;
      S_WIMM:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the whole command at the accept edge so the bus is free afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= OP_MOVI;
      r_rd    <= '0;
      r_rn    <= '0;
      r_rm    <= '0;
      r_shift <= SH_NONE;
      r_imm   <= '0;
    end else if (w_accept) begin
      r_op    <= bus.cmd_op;
      r_rd    <= bus.cmd_rd;
      r_rn    <= bus.cmd_rn;
      r_rm    <= bus.cmd_rm;
      r_shift <= bus.cmd_shift;
      r_imm   <= bus.cmd_imm;
    end
  end

  // Operand, result and status registers loaded by the per-state actions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_GETA: r_a <= r_regs[r_rn];
        S_GETB: r_b <= r_regs[r_rm];
        S_EXEC: begin
          if (r_op != OP_CMP)       r_c     <= w_alu_result;
          if (op_sets_flags(r_op))  r_flags <= w_alu_flags;
        end
        S_WIMM: r_c <= r_imm;
        default: ;
      endcase
    end
  end

  // Completion pulse lines up with the first IDLE cycle after a command.
  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= (r_state != S_IDLE) && (w_state_next == S_IDLE);
  end

  // Single write port: WB stores C, WIMM stores the immediate directly.
  always_comb begin
    w_wr_en   = (r_state == S_WB) || (r_state == S_WIMM);
    w_wr_data = (r_state == S_WIMM) ? r_imm : r_c;
  end

  // Register file; cleared on reset so no write survives an aborted command.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[r_rd] <= w_wr_data;
    end
  end

  assign bus.cmd_ready    = (r_state == S_IDLE);
  assign bus.done         = r_done;
  assign bus.datapath_out = r_c;
  assign bus.Z_out        = r_flags.z;
  assign bus.N_out        = r_flags.n;
  assign bus.V_out        = r_flags.v;
  assign bus.dbg_data     = r_regs[bus.dbg_addr];

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: directed plan steps plus random commands,
// checked against an arithmetic reference model of the instruction set.
module tb_datapath_seq;
  import datapath_seq_pkg::*;

  localparam int W  = 16;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datapath_seq_if #(.DATA_W(W), .NREG(NR)) bus ();
  datapath_seq #(.DATA_W(W), .NREG(NR)) dut (.clk(clk), .reset(reset), .bus(bus));

  datapath_seq_if #(.DATA_W(8), .NREG(4)) bus8 ();
  datapath_seq #(.DATA_W(8), .NREG(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  int checks = 0;
  int errors = 0;

  // Reference architectural state.
  longint unsigned m_regs [NR];
  longint unsigned m_c;
  bit m_z, m_n, m_v;
  int exp_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned shf(longint unsigned v, int sh, int w);
    longint unsigned mask = (64'd1 << w) - 1;
    case (sh)
      1:       return (v << 1) & mask;
      2:       return v >> 1;
      3:       return (v >> 1) | (v & (64'd1 << (w - 1)));
      default: return v;
    endcase
  endfunction

  function automatic longint sgn(longint unsigned v, int w);
    if (v >= (64'd1 << (w - 1))) return longint'(v) - longint'(64'd1 << w);
    return longint'(v);
  endfunction

  function automatic bit ovf(longint s, int w);
    longint lim = longint'(64'd1 << (w - 1));
    return (s > lim - 1) || (s < -lim);
  endfunction

  // Apply one instruction to the reference state and set the expected latency.
  task automatic model_exec(input op_e op, input int rd, input int rn, input int rm,
                            input int sh, input longint unsigned imm);
    longint unsigned mask = (64'd1 << W) - 1;
    longint unsigned av = m_regs[rn];
    longint unsigned bv = shf(m_regs[rm], sh, W);
    longint unsigned r = 0;
    bit setf = 1'b1;
    bit v = 1'b0;
    case (op)
      OP_MOVI: begin r = imm & mask; m_regs[rd] = r; m_c = r; setf = 0; exp_lat = 2; end
      OP_MOV:  begin r = bv; m_regs[rd] = r; m_c = r; setf = 0; exp_lat = 4; end
      OP_MVN:  begin r = ~bv & mask; m_regs[rd] = r; m_c = r; exp_lat = 4; end
      OP_ADD:  begin r = (av + bv) & mask; v = ovf(sgn(av, W) + sgn(bv, W), W);
                     m_regs[rd] = r; m_c = r; exp_lat = 5; end
      OP_AND:  begin r = av & bv; m_regs[rd] = r; m_c = r; exp_lat = 5; end
      OP_CMP:  begin r = (av - bv) & mask; v = ovf(sgn(av, W) - sgn(bv, W), W); exp_lat = 4; end
      default: begin setf = 0; exp_lat = 0; end
    endcase
    if (setf) begin
      m_z = (r == 0);
      m_n = ((r >> (W - 1)) & 1) != 0;
      m_v = v;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      check($sformatf("%s R%0d", tag, i), 32'(bus.dbg_data), 32'(m_regs[i]));
    end
  endtask

  // Present a command at the current negedge and let it be accepted.
  task automatic start_cmd(input op_e op, input int rd, input int rn, input int rm,
                           input shift_e sh, input logic [15:0] imm);
    bus.cmd_op    = op;
    bus.cmd_rd    = 3'(rd);
    bus.cmd_rn    = 3'(rn);
    bus.cmd_rm    = 3'(rm);
    bus.cmd_shift = sh;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    #1 check("cmd_ready idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = op_e'(3'($urandom_range(0, 5)));
    bus.cmd_rd    = 3'($urandom);
    bus.cmd_rn    = 3'($urandom);
    bus.cmd_rm    = 3'($urandom);
    bus.cmd_shift = shift_e'(2'($urandom));
    bus.cmd_imm   = 16'($urandom);
    model_exec(op, rd, rn, rm, int'(sh), 64'(imm));
  endtask

  // Wait (bounded) for done; optionally offer a conflicting MOVI while busy.
  task automatic wait_done(input string tag, input bit poke);
    int lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (poke) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_MOVI;
        bus.cmd_rd    = 3'd0;
        bus.cmd_imm   = 16'hDEAD;
        #1 check({tag, " busy ready"}, 32'(bus.cmd_ready), 32'd0);
      end
    end
    bus.cmd_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " dout"}, 32'(bus.datapath_out), 32'(m_c));
    check({tag, " ZNV"}, 32'({bus.Z_out, bus.N_out, bus.V_out}), 32'({m_z, m_n, m_v}));
  endtask

  task automatic finish_cmd(input string tag);
    @(negedge clk);
    check({tag, " done width"}, 32'(bus.done), 32'd0);
    check_regs(tag);
  endtask

  task automatic run(input string tag, input op_e op, input int rd, input int rn, input int rm,
                     input shift_e sh, input logic [15:0] imm, input bit poke);
    @(negedge clk);
    start_cmd(op, rd, rn, rm, sh, imm);
    wait_done(tag, poke);
    finish_cmd(tag);
  endtask

  task automatic run8(input op_e op, input int rd, input int rn, input int rm, input logic [7:0] imm);
    bit got = 1'b0;
    @(negedge clk);
    bus8.cmd_op    = op;
    bus8.cmd_rd    = 2'(rd);
    bus8.cmd_rn    = 2'(rn);
    bus8.cmd_rm    = 2'(rm);
    bus8.cmd_shift = SH_NONE;
    bus8.cmd_imm   = imm;
    bus8.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus8.cmd_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("dut8 done seen", 32'(got), 32'd1);
  endtask

  initial begin
    bit seen;
    bus.cmd_valid = 0; bus.cmd_op = OP_MOVI; bus.cmd_rd = 0; bus.cmd_rn = 0; bus.cmd_rm = 0;
    bus.cmd_shift = SH_NONE; bus.cmd_imm = 0; bus.dbg_addr = 0;
    bus8.cmd_valid = 0; bus8.cmd_op = OP_MOVI; bus8.cmd_rd = 0; bus8.cmd_rn = 0; bus8.cmd_rm = 0;
    bus8.cmd_shift = SH_NONE; bus8.cmd_imm = 0; bus8.dbg_addr = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    m_c = 0; m_z = 0; m_n = 0; m_v = 0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset ready", 32'(bus.cmd_ready), 32'd1);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset dout", 32'(bus.datapath_out), 32'd0);
    check("reset ZNV", 32'({bus.Z_out, bus.N_out, bus.V_out}), 32'd0);
    check_regs("reset");

    // Directed plan: add with shifted operand, compare with overflow, MVN/MOV.
    run("MOVI R0", OP_MOVI, 0, 0, 0, SH_NONE, 16'd7, 0);
    run("MOVI R1", OP_MOVI, 1, 0, 0, SH_NONE, 16'd2, 0);
    run("ADD R2", OP_ADD, 2, 1, 0, SH_LSL1, 16'd0, 0);
    bus.dbg_addr = 3'd2;
    #1 check("plan R2 value", 32'(bus.dbg_data), 32'h0010);
    run("MOVI R3", OP_MOVI, 3, 0, 0, SH_NONE, 16'h7FFF, 0);
    run("MOVI R4", OP_MOVI, 4, 0, 0, SH_NONE, 16'hFFFF, 0);
    run("CMP R3,R4", OP_CMP, 0, 3, 4, SH_NONE, 16'd0, 0);
    check("plan CMP ZNV", 32'({bus.Z_out, bus.N_out, bus.V_out}), 32'b011);
    run("MVN R5", OP_MVN, 5, 0, 0, SH_ASR1, 16'd0, 0);
    bus.dbg_addr = 3'd5;
    #1 check("plan R5 value", 32'(bus.dbg_data), 32'hFFFC);
    run("MOV R6", OP_MOV, 6, 0, 5, SH_LSR1, 16'd0, 0);
    check("plan MOV keeps N", 32'(bus.N_out), 32'd1);

    // Busy commands are ignored; aliasing ADD R1,R1,R1 doubles R1.
    run("ADD busy", OP_ADD, 1, 1, 1, SH_NONE, 16'd0, 1);

    // Back-to-back: next command presented in the done cycle.
    @(negedge clk);
    start_cmd(OP_AND, 7, 5, 3, SH_NONE, 16'd0);
    wait_done("b2b AND", 0);
    start_cmd(OP_MOVI, 0, 0, 0, SH_NONE, 16'h1234);
    wait_done("b2b MOVI", 0);
    finish_cmd("b2b");

    // Random commands against the model.
    for (int t = 0; t < 40; t++) begin
      run($sformatf("rand%0d", t), op_e'(3'($urandom_range(0, 5))), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          shift_e'(2'($urandom_range(0, 3))), 16'($urandom), 0);
    end

    // Reset during EXEC of an ADD aborts it with no write.
    run("pre MOVI R1", OP_MOVI, 1, 0, 0, SH_NONE, 16'd5, 0);
    @(negedge clk);
    start_cmd(OP_ADD, 2, 1, 1, SH_NONE, 16'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    m_c = 0; m_z = 0; m_n = 0; m_v = 0;
    check("abort ready", 32'(bus.cmd_ready), 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("abort no done", 32'(seen), 32'd0);
    check("abort dout", 32'(bus.datapath_out), 32'd0);
    check_regs("abort");

    // Narrow instance: 8-bit overflow and zero cases.
    run8(OP_MOVI, 0, 0, 0, 8'h7F);
    run8(OP_MOVI, 1, 0, 0, 8'h01);
    run8(OP_ADD, 2, 0, 1, 8'h00);
    check("dut8 ADD result", 32'(bus8.datapath_out), 32'h80);
    check("dut8 ADD ZNV", 32'({bus8.Z_out, bus8.N_out, bus8.V_out}), 32'b011);
    run8(OP_ADD, 3, 2, 2, 8'h00);
    check("dut8 ADD2 result", 32'(bus8.datapath_out), 32'h00);
    check("dut8 ADD2 ZNV", 32'({bus8.Z_out, bus8.N_out, bus8.V_out}), 32'b101);
    bus8.dbg_addr = 2'd2;
    #1 check("dut8 R2", 32'(bus8.dbg_data), 32'h80);
    bus8.dbg_addr = 2'd3;
    #1 check("dut8 R3", 32'(bus8.dbg_data), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
